// File: rtl/tmds_pkg.sv
// Shared TMDS constants: control/guard code words, HDMI sequencing states and helpers.
package tmds_pkg;

  localparam int DISP_W = 5;

  localparam logic [9:0] CTL_TOK_00 = 10'h354;
  localparam logic [9:0] CTL_TOK_01 = 10'h0AB;
  localparam logic [9:0] CTL_TOK_10 = 10'h154;
  localparam logic [9:0] CTL_TOK_11 = 10'h2AB;

  localparam logic [9:0] GB_CH1   = 10'h133;
  localparam logic [9:0] GB_OTHER = 10'h2CC;

  typedef enum logic [1:0] {ST_CTRL, ST_PRE, ST_GUARD, ST_VIDEO} hdmi_st_e;

  function automatic logic [3:0] popcnt8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  function automatic logic [9:0] ctl_token(input logic [1:0] c);
    logic [9:0] t;
    case (c)
      2'b00:   t = CTL_TOK_00;
      2'b01:   t = CTL_TOK_01;
      2'b10:   t = CTL_TOK_10;
      default: t = CTL_TOK_11;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/tmds_ch_encoder.sv
// One TMDS channel: 8b/10b video with running disparity, 2b/10b control tokens,
// and a guard-band override word. Output is registered.
module tmds_ch_encoder
  import tmds_pkg::*;
#(
  parameter logic [9:0] GB_WORD = GB_OTHER
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       de,
  input  logic       guard,
  input  logic [1:0] ctl,
  input  logic [7:0] din,
  output logic [9:0] dout
);

  logic [DISP_W-1:0] cnt_d, cnt_q, diff, two_qm8, two_nqm8;
  logic [9:0]        dout_d, dout_q;
  logic [8:0]        q_m;
  logic [3:0]        n1d, n1q;
  logic              use_xnor, acc, cnt_zero, cnt_neg, cnt_pos;

  always_comb begin
    n1d      = popcnt8(din);
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !din[0]);
    acc      = din[0];
    q_m[0]   = din[0];
    for (int i = 1; i < 8; i++) begin
      acc    = use_xnor ? ~(acc ^ din[i]) : (acc ^ din[i]);
      q_m[i] = acc;
    end
    q_m[8] = ~use_xnor;

    // diff = ones(q_m) - zeros(q_m); all disparity math is modulo 2^DISP_W
    n1q      = popcnt8(q_m[7:0]);
    diff     = DISP_W'({n1q, 1'b0}) - DISP_W'(8);
    two_qm8  = DISP_W'({q_m[8], 1'b0});
    two_nqm8 = DISP_W'({~q_m[8], 1'b0});
    cnt_zero = (cnt_q == '0);
    cnt_neg  = cnt_q[DISP_W-1];
    cnt_pos  = !cnt_neg && !cnt_zero;

    dout_d = ctl_token(ctl);
    cnt_d  = '0;
    if (guard) begin
      dout_d = GB_WORD;
    end else if (de) begin
      if (cnt_zero || (n1q == 4'd4)) begin
        dout_d = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
        cnt_d  = q_m[8] ? (cnt_q + diff) : (cnt_q - diff);
      end else if ((cnt_pos && (n1q > 4'd4)) || (cnt_neg && (n1q < 4'd4))) begin
        dout_d = {1'b1, q_m[8], ~q_m[7:0]};
        cnt_d  = cnt_q + two_qm8 - diff;
      end else begin
        dout_d = {1'b0, q_m[8], q_m[7:0]};
        cnt_d  = cnt_q - two_nqm8 + diff;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout_q <= '0;
      cnt_q  <= '0;
    end else begin
      dout_q <= dout_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/tmds_multi_encoder.sv
// N-channel TMDS encoder (ch0 carries hs/vs). Define TMDS_HDMI_GUARD_EN to add the
// HDMI video preamble + leading guard band via a delay line and sequencing FSM.
module tmds_multi_encoder
  import tmds_pkg::*;
#(
  parameter int NUM_CH  = 3,
  parameter int PRE_LEN = 8,
  parameter int GB_LEN  = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_de,
  input  logic                    i_hs,
  input  logic                    i_vs,
  input  logic [2*(NUM_CH-1)-1:0] i_ctl,
  input  logic [8*NUM_CH-1:0]     i_din,
  output logic [10*NUM_CH-1:0]    o_dout,
  output logic                    o_de,
  output logic                    o_seq_err
);

  localparam int CTL_W = 2*(NUM_CH-1);
  localparam int PIX_W = 3 + CTL_W + 8*NUM_CH;

  logic [PIX_W-1:0]          pix_d, pix_q, tail;
  logic                      t_de, t_hs, t_vs;
  logic [CTL_W-1:0]          t_ctl;
  logic [8*NUM_CH-1:0]       t_din;
  logic [NUM_CH-1:0]         ch_de;
  logic [NUM_CH-1:0][1:0]    ch_ctl;
  logic                      ch_guard;
  logic                      de_d, de_q;

  always_comb pix_d = {i_de, i_vs, i_hs, i_ctl, i_din};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pix_q <= '0;
    else       pix_q <= pix_d;
  end

  assign {t_de, t_vs, t_hs, t_ctl, t_din} = tail;

`ifdef TMDS_HDMI_GUARD_EN
  localparam int L     = PRE_LEN + GB_LEN;
  localparam int CNT_W = $clog2(L) + 1;

  logic [L-1:0][PIX_W-1:0] dl_d, dl_q;
  hdmi_st_e                state_q;
  logic [CNT_W-1:0]        pcnt_q;
  logic                    seq_err_q, head_rise;

  always_comb begin
    dl_d[0] = pix_q;
    for (int i = 1; i < L; i++) dl_d[i] = dl_q[i-1];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) dl_q <= '0;
    else       dl_q <= dl_d;
  end

  assign tail = dl_q[L-1];

  // Rise is seen one clock before the input register so PRE starts exactly L clocks
  // ahead of the first delayed video word.
  assign head_rise = i_de & ~pix_q[PIX_W-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_CTRL;
      pcnt_q    <= '0;
      seq_err_q <= 1'b0;
    end else begin
      seq_err_q <= head_rise && (state_q != ST_CTRL);
      case (state_q)
        ST_CTRL: if (head_rise) begin
          state_q <= ST_PRE;
          pcnt_q  <= '0;
        end
        ST_PRE: if (pcnt_q == CNT_W'(PRE_LEN-1)) begin
          state_q <= ST_GUARD;
          pcnt_q  <= '0;
        end else pcnt_q <= pcnt_q + 1'b1;
        ST_GUARD: if (pcnt_q == CNT_W'(GB_LEN-1)) begin
          state_q <= ST_VIDEO;
          pcnt_q  <= '0;
        end else pcnt_q <= pcnt_q + 1'b1;
        ST_VIDEO: if (!t_de) state_q <= ST_CTRL;
        default:  state_q <= ST_CTRL;
      endcase
    end
  end

  assign o_seq_err = seq_err_q;
`else
  assign tail      = pix_q;
  assign o_seq_err = 1'b0;
`endif

  always_comb begin
    ch_de     = {NUM_CH{t_de}};
    ch_guard  = 1'b0;
    de_d      = t_de;
    ch_ctl[0] = {t_vs, t_hs};
    for (int k = 1; k < NUM_CH; k++) ch_ctl[k] = t_ctl[2*(k-1) +: 2];
`ifdef TMDS_HDMI_GUARD_EN
    if (state_q == ST_PRE) begin
      ch_de = '0;
      de_d  = 1'b0;
      for (int k = 1; k < NUM_CH; k++) ch_ctl[k] = (k == 1) ? 2'b01 : 2'b00;
    end
    if (state_q == ST_GUARD) begin
      ch_guard = 1'b1;
      de_d     = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) de_q <= 1'b0;
    else       de_q <= de_d;
  end

  assign o_de = de_q;

  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      tmds_ch_encoder #(
        .GB_WORD ((k == 1) ? GB_CH1 : GB_OTHER)
      ) u_ch (
        .clk   (clk),
        .rstn  (rstn),
        .de    (ch_de[k]),
        .guard (ch_guard),
        .ctl   (ch_ctl[k]),
        .din   (t_din[8*k +: 8]),
        .dout  (o_dout[10*k +: 10])
      );
    end
  endgenerate

endmodule
